// File: rtl/seq_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_addsub_pkg
// Brief    : Shared FSM encoding and slice-geometry check for multi-cycle
//            arithmetic blocks.
// Revision : 1.0
// ============================================================================
package seq_addsub_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // True when SLICE legally tiles WIDTH with no remainder.
    function automatic bit slice_fits(input int width, input int slice);
        return (slice >= 1) && (slice <= width) && ((width % slice) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// ============================================================================
// Module   : addsub_slice
// Brief    : Combinational SLICE-bit ripple adder built from full_adder cells.
// Revision : 1.0
// ============================================================================
module addsub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);
    logic [SLICE:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < SLICE; i++) begin : g_bit
            full_adder u_fa (
                .a    (x[i]),
                .b    (y[i]),
                .cin  (w_c[i]),
                .s    (s[i]),
                .cout (w_c[i+1])
            );
        end
    endgenerate

    assign cout     = w_c[SLICE];
    // Carry into the top bit, needed for signed overflow on the final slice.
    assign c_msb_in = w_c[SLICE-1];
endmodule
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Brief    : One-bit full adder cell.
// Revision : 1.0
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule
`default_nettype wire

// File: rtl/seq_addsub.sv
`default_nettype none
// ============================================================================
// Module   : seq_addsub
// Brief    : Multi-cycle two's-complement adder/subtractor, SLICE bits/clock,
//            with start/busy/done handshake and carry/overflow/zero flags.
// Revision : 1.0
// ============================================================================
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NSLICE - 1);

    generate
        if (!slice_fits(WIDTH, SLICE)) begin : g_bad_slice
            $error("seq_addsub: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic [SLICE-1:0] w_x;
    logic [SLICE-1:0] w_y;
    logic [SLICE-1:0] w_s;
    logic             w_cout;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_result;
    logic             w_last;

    assign w_x    = r_a[r_cnt*SLICE +: SLICE];
    assign w_y    = r_b[r_cnt*SLICE +: SLICE];
    assign w_last = (r_cnt == C_LAST);

    addsub_slice #(.SLICE(SLICE)) u_slice (
        .x        (w_x),
        .y        (w_y),
        .cin      (r_carry),
        .s        (w_s),
        .cout     (w_cout),
        .c_msb_in (w_cmsb)
    );

    // Full result as it will stand once the current slice is written back.
    always_comb begin
        w_result = r_acc;
        w_result[r_cnt*SLICE +: SLICE] = w_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // Subtract as a + ~b + 1: invert B and seed the carry.
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{subtract}};
                        r_carry <= subtract;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    r_acc[r_cnt*SLICE +: SLICE] <= w_s;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state  <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= w_result;
                        carryout <= w_cout;
                        overflow <= w_cout ^ w_cmsb;
                        zero     <= ~|w_result;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_seq_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_addsub
// Brief    : Self-checking bench for seq_addsub at 4/4, 8/4 and 32/4.
// Revision : 1.0
// ============================================================================
module tb_seq_addsub;

    typedef struct packed {
        logic [31:0] sum;
        logic        co;
        logic        ov;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b;
    logic        subtract;
    logic [2:0]  start_v;

    logic        busy4, done4, co4, ov4, z4;
    logic [3:0]  sum4;
    logic        busy8, done8, co8, ov8, z8;
    logic [7:0]  sum8;
    logic        busy32, done32, co32, ov32, z32;
    logic [31:0] sum32;

    int          sel;
    logic        busy_m, done_m, co_m, ov_m, z_m;
    logic [31:0] sum_m;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] prev_sum [3];
    logic        prev_z   [3];

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(4), .SLICE(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start_v[0]), .subtract(subtract),
        .a(a[3:0]), .b(b[3:0]), .busy(busy4), .done(done4), .sum(sum4),
        .carryout(co4), .overflow(ov4), .zero(z4)
    );

    seq_addsub #(.WIDTH(8), .SLICE(4)) u_dut8 (
        .clk(clk), .reset(reset), .start(start_v[1]), .subtract(subtract),
        .a(a[7:0]), .b(b[7:0]), .busy(busy8), .done(done8), .sum(sum8),
        .carryout(co8), .overflow(ov8), .zero(z8)
    );

    seq_addsub u_dut32 (
        .clk(clk), .reset(reset), .start(start_v[2]), .subtract(subtract),
        .a(a), .b(b), .busy(busy32), .done(done32), .sum(sum32),
        .carryout(co32), .overflow(ov32), .zero(z32)
    );

    always_comb begin
        busy_m = busy32; done_m = done32; sum_m = sum32;
        co_m = co32; ov_m = ov32; z_m = z32;
        if (sel == 0) begin
            busy_m = busy4; done_m = done4; sum_m = {28'b0, sum4};
            co_m = co4; ov_m = ov4; z_m = z4;
        end else if (sel == 1) begin
            busy_m = busy8; done_m = done8; sum_m = {24'b0, sum8};
            co_m = co8; ov_m = ov8; z_m = z8;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference: exact integer arithmetic, reduced modulo 2^w afterwards.
    function automatic res_t model(input int w, input logic [31:0] av, input logic [31:0] bv, input bit sub);
        res_t   r;
        longint mask, half, ua, ub, full, sa, sb, exact;
        mask  = (64'sd1 <<< w) - 1;
        half  = 64'sd1 <<< (w - 1);
        ua    = {32'b0, av} & mask;
        ub    = {32'b0, bv} & mask;
        full  = sub ? (ua + ((~ub) & mask) + 1) : (ua + ub);
        sa    = (ua >= half) ? ua - (half * 2) : ua;
        sb    = (ub >= half) ? ub - (half * 2) : ub;
        exact = sub ? (sa - sb) : (sa + sb);
        r.sum = 32'(full & mask);
        r.co  = full[w];
        r.ov  = (exact < -half) || (exact >= half);
        r.z   = (r.sum == 32'd0);
        return r;
    endfunction

    function automatic int width_of(input int s);
        return (s == 0) ? 4 : (s == 1) ? 8 : 32;
    endfunction

    task automatic run_op(input int s, input logic [31:0] av, input logic [31:0] bv,
                          input bit sub, input bit poke);
        res_t e;
        int   w, n;
        w   = width_of(s);
        e   = model(w, av, bv, sub);
        sel = s;
        @(negedge clk);
        a = av; b = bv; subtract = sub; start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        chk("accept_busy", busy_m, 1);
        chk("accept_done", done_m, 0);
        chk("run_hold_sum", sum_m, prev_sum[s]);
        chk("run_hold_zero", z_m, prev_z[s]);
        // Operands and mode change mid-run; optionally a stray start too.
        a = ~av; b = bv ^ 32'h5a5a_5a5a; subtract = ~sub;
        if (poke) start_v[s] = 1'b1;
        @(negedge clk);
        n = 1;
        start_v[s] = 1'b0;
        while (!done_m && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, w / 4);
        chk("sum", sum_m, e.sum);
        chk("carryout", co_m, e.co);
        chk("overflow", ov_m, e.ov);
        chk("zero", z_m, e.z);
        prev_sum[s] = e.sum;
        prev_z[s]   = e.z;
        @(negedge clk);
        chk("done_pulse", done_m, 0);
        chk("idle_busy", busy_m, 0);
        chk("hold_sum", sum_m, e.sum);
    endtask

    initial begin
        res_t        e;
        int          n;
        logic [31:0] op_a [4];
        logic [31:0] op_b [4];
        bit          op_s [4];
        bit          seen;

        reset = 1'b1; start_v = '0; a = '0; b = '0; subtract = 1'b0; sel = 0;
        for (int i = 0; i < 3; i++) begin prev_sum[i] = '0; prev_z[i] = 1'b0; end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_busy", busy_m, 0);
            chk("rst_done", done_m, 0);
            chk("rst_sum", sum_m, 0);
            chk("rst_flags", {co_m, ov_m, z_m}, 0);
        end

        // 8/4 directed corners
        run_op(1, 32'h7F, 32'h01, 1'b0, 1'b0);
        run_op(1, 32'hFF, 32'hFF, 1'b0, 1'b1);
        run_op(1, 32'h80, 32'h01, 1'b1, 1'b0);

        // 32/4: zero result, then it must hold across idle cycles
        run_op(2, 32'h5, 32'h5, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("idle_hold_sum", sum_m, 0);
        chk("idle_hold_zero", z_m, 1);

        for (int i = 0; i < 20; i++)
            run_op(2, $urandom, $urandom, 1'($urandom), 1'($urandom));

        // Back-to-back with start held: acceptance lands in each done cycle,
        // so done pulses repeat every NSLICE+1 edges.
        for (int k = 0; k < 4; k++) begin
            op_a[k] = $urandom; op_b[k] = $urandom; op_s[k] = 1'($urandom);
        end
        sel = 2;
        @(negedge clk);
        a = op_a[0]; b = op_b[0]; subtract = op_s[0]; start_v[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("b2b_busy", busy_m, 1);
            chk("b2b_done_low", done_m, 0);
            if (k < 3) begin
                a = op_a[k+1]; b = op_b[k+1]; subtract = op_s[k+1];
            end else begin
                start_v[2] = 1'b0;
            end
            n = 0;
            while (!done_m && n < 100) begin
                @(negedge clk);
                n++;
            end
            e = model(32, op_a[k], op_b[k], op_s[k]);
            chk("b2b_latency", n, 8);
            chk("b2b_sum", sum_m, e.sum);
            chk("b2b_flags", {co_m, ov_m, z_m}, {e.co, e.ov, e.z});
            prev_sum[2] = e.sum; prev_z[2] = e.z;
        end
        @(negedge clk);
        chk("b2b_end_done", done_m, 0);
        chk("b2b_end_busy", busy_m, 0);

        // Reset on the 2nd RUN edge of a 32/4 operation
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; subtract = 1'b0; start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", busy_m, 0);
        chk("mid_rst_done", done_m, 0);
        chk("mid_rst_sum", sum_m, 0);
        chk("mid_rst_flags", {co_m, ov_m, z_m}, 0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done_m) seen = 1'b1;
        end
        chk("mid_rst_no_done", seen, 0);
        for (int i = 0; i < 3; i++) begin prev_sum[i] = '0; prev_z[i] = 1'b0; end
        run_op(2, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);

        // 4/4 exhaustive, both modes
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    run_op(0, 32'(x), 32'(y), 1'(m), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
